pipe_alu_md: RTL and testbench

Parametrised execute-stage ALU for the pipelined CPU. It keeps the forwarding-select front end and single-cycle integer operations. It adds shifts by register, NOR and LUI, plus an iterative multiply/divide unit with architectural HI/LO registers and a Busy stall output for the hazard unit. It sits in EX, between the ID/EX and EX/MEM pipeline registers.

---
 rtl/pipe_alu_pkg.sv | 47 ++++
 rtl/md_iter.sv | 161 ++++++++++++++++
 rtl/pipe_alu_md.sv | 109 ++++++++++
 tb/tb_pipe_alu_md.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: shared constants for the EX-stage ALU and its multiply/divide unit.
//   - ALUCtr operation codes OP_ADD .. OP_MFLO
//   - forwarding-select codes FWD_REG, FWD_WB, FWD_MEM
//   - multiply/divide FSM state type md_state_t (MD_IDLE, MD_RUN, MD_FIX)
//   - md_start_op(): which codes may launch the iterative unit
// Build option: PIPE_ALU_DIV_EN enables DIVU/DIV in the iterative unit.
package pipe_alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_SLL   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_NOR   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Codes that may launch the iterative unit; divide codes only when built in.
  function automatic logic md_start_op(input logic [4:0] op);
`ifdef PIPE_ALU_DIV_EN
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
`else
    return (op == OP_MULTU) || (op == OP_MULT);
`endif
  endfunction

endpackage

// File: rtl/md_iter.sv
// md_iter: iterative multiply/divide unit with architectural HI/LO.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_start, i_flush     launch request / abort of an in-flight op
//   i_op                 ALUCtr code sampled with i_start
//   i_a, i_b             operands (multiplicand/dividend in i_a, divisor in i_b)
//   o_hi, o_lo           architectural HI/LO
//   o_busy, o_done       op in progress / one-cycle pulse after HI/LO written
//   o_state              current FSM state (debug)
// Build option: PIPE_ALU_DIV_EN includes the restoring divider.
// Handshake: i_start is accepted only on an edge where the unit is idle, i_flush
// is low and i_op is a launchable code; otherwise it is dropped, never queued.
import pipe_alu_pkg::*;

module md_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output md_state_t        o_state
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  md_state_t          r_state, w_state_nxt;
  logic [SHW-1:0]     r_cnt;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg_q;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_start_ok, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_step, w_prod;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

`ifdef PIPE_ALU_DIV_EN
  logic               r_is_div, r_neg_r, r_dz;
  logic [WIDTH:0]     w_div_shift, w_div_diff;
`endif

  assign w_start_ok = i_start && !i_flush && (r_state == MD_IDLE) && md_start_op(i_op);
  assign w_signed   = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg    = w_signed && i_a[WIDTH-1];
  assign w_b_neg    = w_signed && i_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_start_ok) w_state_nxt = MD_RUN;
      MD_RUN: begin
        if (i_flush)                w_state_nxt = MD_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = MD_FIX;
      end
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // One iteration step. The multiply adder keeps its carry so the unsigned
  // product of two full-scale magnitudes never loses its top bit.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_step    = {w_mul_sum, r_acc[WIDTH-1:1]};
`ifdef PIPE_ALU_DIV_EN
    // Restoring step: shifted remainder minus divisor; bit WIDTH is the borrow.
    w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff  = w_div_shift - {1'b0, r_mcand};
    if (r_is_div) begin
      if (w_div_diff[WIDTH]) w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      else                   w_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sign correction applied in FIX. A zero divisor yields an all-ones quotient
  // and leaves the dividend (sign restored) in the remainder.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
`ifdef PIPE_ALU_DIV_EN
    if (r_is_div) begin
      w_fix_lo = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
      w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
`ifdef PIPE_ALU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_start_ok) begin
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
            r_mcand <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef PIPE_ALU_DIV_EN
            r_is_div <= (i_op == OP_DIVU) || (i_op == OP_DIV);
            r_neg_r  <= w_a_neg;
            r_dz     <= (i_b == '0);
`endif
          end
        end
        MD_RUN: begin
          if (!i_flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_step;
          end
        end
        MD_FIX: begin
          if (!i_flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != MD_IDLE);
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: rtl/pipe_alu_md.sv
// pipe_alu_md: EX-stage ALU with forwarding muxes and an iterative mul/div unit.
// Ports:
//   CLK, Reset                      clock, asynchronous active-high reset
//   ALUCtr                          operation code (pipe_alu_pkg OP_*)
//   ALUSrcA, ALUSrcB                A: rs / zero-extended sa;  B: rt / ExtData
//   ForwardA, ForwardB              operand forwarding selects
//   ReadData1/2, ExtData,
//   WB_WriteData, MEM_ALUResult     operand sources
//   sa                              shift amount
//   Start, Flush                    launch / abort multiply-divide
//   EX_ALUResult, Zero, Sign        combinational result and flags
//   TempDataA, TempDataB            forwarded operands (B is store data)
//   Busy, Done                      mul/div in progress / HI-LO written pulse
//   o_dbg_state                     mul/div FSM state (debug)
// Build option: PIPE_ALU_DIV_EN enables DIVU/DIV.
import pipe_alu_pkg::*;

module pipe_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       ALUCtr,
  input  logic             ALUSrcA,
  input  logic             ALUSrcB,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] ExtData,
  input  logic [WIDTH-1:0] WB_WriteData,
  input  logic [WIDTH-1:0] MEM_ALUResult,
  input  logic [SHW-1:0]   sa,
  input  logic             Start,
  input  logic             Flush,
  output logic [WIDTH-1:0] EX_ALUResult,
  output logic             Zero,
  output logic             Sign,
  output logic [WIDTH-1:0] TempDataA,
  output logic [WIDTH-1:0] TempDataB,
  output logic             Busy,
  output logic             Done,
  output md_state_t        o_dbg_state
);

  logic [WIDTH-1:0] w_in_a, w_in_b, w_result, w_hi, w_lo;
  logic [SHW-1:0]   w_shamt;

  always_comb begin
    case (ForwardA)
      FWD_WB:  TempDataA = WB_WriteData;
      FWD_MEM: TempDataA = MEM_ALUResult;
      FWD_REG: TempDataA = ReadData1;
      default: TempDataA = ReadData1;
    endcase
    case (ForwardB)
      FWD_WB:  TempDataB = WB_WriteData;
      FWD_MEM: TempDataB = MEM_ALUResult;
      FWD_REG: TempDataB = ReadData2;
      default: TempDataB = ReadData2;
    endcase
  end

  assign w_in_a  = ALUSrcA ? {{(WIDTH-SHW){1'b0}}, sa} : TempDataA;
  assign w_in_b  = ALUSrcB ? ExtData : TempDataB;
  assign w_shamt = w_in_a[SHW-1:0];

  // Codes 12-15 and unused codes fall through to zero.
  always_comb begin
    case (ALUCtr)
      OP_ADD:  w_result = w_in_a + w_in_b;
      OP_SUB:  w_result = w_in_a - w_in_b;
      OP_AND:  w_result = w_in_a & w_in_b;
      OP_OR:   w_result = w_in_a | w_in_b;
      OP_SLL:  w_result = w_in_b << w_shamt;
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (w_in_a < w_in_b)};
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_in_a) < $signed(w_in_b))};
      OP_XOR:  w_result = w_in_a ^ w_in_b;
      OP_SRL:  w_result = w_in_b >> w_shamt;
      OP_SRA:  w_result = $signed(w_in_b) >>> w_shamt;
      OP_NOR:  w_result = ~(w_in_a | w_in_b);
      OP_LUI:  w_result = w_in_b << (WIDTH / 2);
      OP_MFHI: w_result = w_hi;
      OP_MFLO: w_result = w_lo;
      default: w_result = '0;
    endcase
  end

  assign EX_ALUResult = w_result;
  assign Zero         = (w_result == '0);
  assign Sign         = w_result[WIDTH-1];

  md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_md_iter (
    .i_clk   (CLK),
    .i_rst   (Reset),
    .i_start (Start),
    .i_flush (Flush),
    .i_op    (ALUCtr),
    .i_a     (w_in_a),
    .i_b     (w_in_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (Busy),
    .o_done  (Done),
    .o_state (o_dbg_state)
  );

endmodule

// File: tb/tb_pipe_alu_md.sv
// tb_pipe_alu_md: randomized self-checking bench for pipe_alu_md (WIDTH = 32).
import pipe_alu_pkg::*;

module tb_pipe_alu_md;

  localparam int W = 32;

  logic         CLK, Reset;
  logic [4:0]   ALUCtr;
  logic         ALUSrcA, ALUSrcB;
  logic [1:0]   ForwardA, ForwardB;
  logic [W-1:0] ReadData1, ReadData2, ExtData, WB_WriteData, MEM_ALUResult;
  logic [4:0]   sa;
  logic         Start, Flush;
  logic [W-1:0] EX_ALUResult, TempDataA, TempDataB;
  logic         Zero, Sign, Busy, Done;
  md_state_t    dbg_state;

  pipe_alu_md dut (
    .CLK(CLK), .Reset(Reset), .ALUCtr(ALUCtr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ExtData(ExtData), .WB_WriteData(WB_WriteData), .MEM_ALUResult(MEM_ALUResult), .sa(sa),
    .Start(Start), .Flush(Flush), .EX_ALUResult(EX_ALUResult), .Zero(Zero), .Sign(Sign),
    .TempDataA(TempDataA), .TempDataB(TempDataB), .Busy(Busy), .Done(Done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    Reset = 1'b1;
    ALUCtr = 5'd0; ALUSrcA = 0; ALUSrcB = 0; ForwardA = 0; ForwardB = 0;
    ReadData1 = 0; ReadData2 = 0; ExtData = 0; WB_WriteData = 0; MEM_ALUResult = 0;
    sa = 0; Start = 0; Flush = 0;
  end

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] fwd_ref(input logic [1:0] sel, input logic [W-1:0] reg_v);
    if (sel == 2'b01) return WB_WriteData;
    if (sel == 2'b10) return MEM_ALUResult;
    return reg_v;
  endfunction

  function automatic logic [W-1:0] alu_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(a % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return b << sh;
      5:  return (a < b) ? 32'd1 : 32'd0;
      6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7:  return a ^ b;
      8:  return b >> sh;
      9:  return int'(b) >>> sh;
      10: return ~(a | b);
      11: return b * 32'd65536;
      16: return model_hi;
      17: return model_lo;
      default: return 32'd0;
    endcase
  endfunction

  // {HI, LO} after a completed multiply/divide.
  function automatic logic [63:0] md_ref(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa_v, sb_v, q, r;
    logic [63:0] p;
    sa_v = longint'($signed(a));
    sb_v = longint'($signed(b));
    p = '0;
    case (op)
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_MULT:  p = sa_v * sb_v;
      OP_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa_v / sb_v;
          r = sa_v % sb_v;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    ALUSrcA = 0; ALUSrcB = 0; ForwardA = 2'b00; ForwardB = 2'b00;
    ReadData1 = a; ReadData2 = b;
  endtask

  task automatic read_hilo(input string tag);
    ALUCtr = OP_MFHI; #1;
    chk({tag, "_hi"}, EX_ALUResult, model_hi);
    ALUCtr = OP_MFLO; #1;
    chk({tag, "_lo"}, EX_ALUResult, model_lo);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Full multiply/divide from an idle negedge; poke raises a stray Start mid-run.
  task automatic md_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [63:0] r;
    int busy_n;
    r = md_ref(op, a, b);
    exp_q.push_back(r[63:32]);
    exp_q.push_back(r[31:0]);
    set_ops(a, b); ALUCtr = op; Start = 1;
    @(negedge CLK);
    Start = 0;
    busy_n = 0;
    while (Busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (poke && busy_n == 5) begin
        set_ops(32'h1234_5678, 32'h0000_0003); Start = 1;
      end else if (poke && busy_n == 6) begin
        Start = 0;
        ALUCtr = OP_MFHI; #1;
        chk("mfhi_while_busy", EX_ALUResult, model_hi);
        ALUCtr = op;
      end
      @(negedge CLK);
    end
    chk("md_busy_cycles", busy_n, W + 1);
    chk("md_done_pulse", Done, 1'b1);
    model_hi = exp_q.pop_front();
    model_lo = exp_q.pop_front();
    read_hilo("md_result");
    @(negedge CLK);
    chk("md_done_clear", Done, 1'b0);
  endtask

  // A launch attempt that must be ignored.
  task automatic md_ignored(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit flush);
    set_ops(a, b); ALUCtr = op; Start = 1; Flush = flush;
    @(negedge CLK);
    Start = 0; Flush = 0;
    chk({tag, "_busy"}, Busy, 1'b0);
    @(negedge CLK);
    chk({tag, "_done"}, Done, 1'b0);
    read_hilo(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] exp_r;
    logic [W-1:0] a_m, b_m;
    int dones;
    int op_i;
    logic [4:0] mop;

    // Reset state
    ALUCtr = OP_MFHI; #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_hi", EX_ALUResult, 32'd0);
    ALUCtr = OP_MFLO; #1;
    chk("rst_lo", EX_ALUResult, 32'd0);
    @(negedge CLK); @(negedge CLK);
    Reset = 0;
    @(negedge CLK);

    // Directed: forwarded add with immediate
    ForwardA = 2'b10; MEM_ALUResult = 32'd5; ALUSrcA = 0; ALUSrcB = 1; ExtData = 32'd3; ALUCtr = OP_ADD;
    #1;
    chk("fwd_add_res", EX_ALUResult, 32'd8);
    chk("fwd_add_zero", Zero, 1'b0);
    chk("fwd_add_tda", TempDataA, 32'd5);

    // Directed: SRA and SLT
    set_ops(32'd4, 32'h8000_0000); ALUCtr = OP_SRA; #1;
    chk("sra_res", EX_ALUResult, 32'hF800_0000);
    chk("sra_sign", Sign, 1'b1);
    set_ops(32'hFFFF_FFFF, 32'd1); ALUCtr = OP_SLT; #1;
    chk("slt_res", EX_ALUResult, 32'd1);

    // Randomized single-cycle ops across forwarding/source selects
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      ReadData1 = pick_val(); ReadData2 = pick_val(); ExtData = pick_val();
      WB_WriteData = pick_val(); MEM_ALUResult = pick_val();
      ForwardA = 2'($urandom_range(0, 3)); ForwardB = 2'($urandom_range(0, 3));
      ALUSrcA = 1'($urandom_range(0, 1)); ALUSrcB = 1'($urandom_range(0, 1));
      sa = 5'($urandom_range(0, 31));
      op_i = $urandom_range(0, 31);
      ALUCtr = 5'(op_i);
      #1;
      a_m = ALUSrcA ? {27'd0, sa} : fwd_ref(ForwardA, ReadData1);
      b_m = ALUSrcB ? ExtData : fwd_ref(ForwardB, ReadData2);
      exp_r = alu_ref(op_i, a_m, b_m);
      chk($sformatf("alu_op%0d_res", op_i), EX_ALUResult, exp_r);
      chk("alu_zero", Zero, (exp_r == 0));
      chk("alu_sign", Sign, exp_r[31]);
      chk("alu_tda", TempDataA, fwd_ref(ForwardA, ReadData1));
      chk("alu_tdb", TempDataB, fwd_ref(ForwardB, ReadData2));
    end
    @(negedge CLK);

    // Multiply / divide directed
    md_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    md_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
`ifdef PIPE_ALU_DIV_EN
    md_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    md_op(OP_DIVU, 32'd9, 32'd0, 1'b0);
    md_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0);
    md_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`else
    md_ignored("divu_off", OP_DIVU, 32'd9, 32'd2, 1'b0);
    md_ignored("div_off", OP_DIV, 32'd9, 32'd2, 1'b0);
`endif

    // Randomized multiply / divide, back-to-back
    for (int i = 0; i < 10; i++) begin
`ifdef PIPE_ALU_DIV_EN
      mop = 5'($urandom_range(12, 15));
`else
      mop = 5'($urandom_range(12, 13));
`endif
      md_op(mop, pick_val(), pick_val(), 1'b0);
    end

    // Flush mid-run: HI/LO kept, no Done
    md_op(OP_MULTU, 32'd11, 32'd13, 1'b0);
    set_ops(32'd6, 32'd7); ALUCtr = OP_MULTU; Start = 1;
    @(negedge CLK);
    Start = 0;
    for (int c = 1; c < 10; c++) @(negedge CLK);
    chk("pre_flush_busy", Busy, 1'b1);
    Flush = 1;
    @(negedge CLK);
    Flush = 0;
    chk("flush_busy", Busy, 1'b0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done === 1'b1) dones++;
      @(negedge CLK);
    end
    chk("flush_no_done", dones, 0);
    read_hilo("flush_keep");

    // Flush and Start together in idle: Flush wins
    md_ignored("flush_start", OP_MULT, 32'd5, 32'd5, 1'b1);

    // Asynchronous reset mid-operation
`ifdef PIPE_ALU_DIV_EN
    set_ops(32'hFFFF_FF9C, 32'd7); ALUCtr = OP_DIV;
`else
    set_ops(32'hFFFF_FF9C, 32'd7); ALUCtr = OP_MULT;
`endif
    Start = 1;
    @(negedge CLK);
    Start = 0;
    for (int c = 0; c < 8; c++) @(negedge CLK);
    #2 Reset = 1;
    #1;
    chk("arst_busy", Busy, 1'b0);
    chk("arst_done", Done, 1'b0);
    model_hi = '0; model_lo = '0;
    read_hilo("arst");
    @(negedge CLK);
    Reset = 0;
    @(negedge CLK);
    md_op(OP_MULTU, 32'd2, 32'd3, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
